regfile_sequencer: RTL

Multi-cycle control FSM that executes one 8-bit register instruction at a time against the 4x8-bit dual-read/single-write register file.
- Accepts an instruction through a valid/ready handshake.
- Drives the register file's read selects and captures both operands.
- Computes the result in a small internal ALU and issues a single write-back.
- Sits between the instruction source and the register file; owns all register file control pins.

---
 rtl/regfile_sequencer.sv | 163 ++++++++++++++++
 1 files changed

// File: rtl/regfile_sequencer.sv
// regfile_sequencer: multi-cycle control FSM driving a 4x8 register file.
// IDLE -> READ -> EXEC -> WB, one instruction per four cycles.
module regfile_sequencer #(
  parameter int DATA_WIDTH  = 8,
  parameter int COUNT_WIDTH = 8
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   instr_valid,
  output logic                   instr_ready,
  input  logic [7:0]             instr,
  input  logic [DATA_WIDTH-1:0]  imm,
  output logic                   rf_write_en,
  output logic [1:0]             rf_write_sel,
  output logic [1:0]             rf_port_a_sel,
  output logic [1:0]             rf_port_b_sel,
  output logic [DATA_WIDTH-1:0]  rf_input_data,
  input  logic [DATA_WIDTH-1:0]  rf_port_a_data,
  input  logic [DATA_WIDTH-1:0]  rf_port_b_data,
  output logic                   busy,
  output logic                   done,
  output logic                   flag_zero,
  output logic                   flag_carry,
  output logic                   illegal,
  output logic [COUNT_WIDTH-1:0] retired_count
);

  typedef enum logic [1:0] {
    IDLE, READ, EXEC, WB
  } state_t;

  localparam logic [3:0] OP_NOP = 4'h0;
  localparam logic [3:0] OP_ADD = 4'h1;
  localparam logic [3:0] OP_SUB = 4'h2;
  localparam logic [3:0] OP_AND = 4'h3;
  localparam logic [3:0] OP_OR  = 4'h4;
  localparam logic [3:0] OP_XOR = 4'h5;
  localparam logic [3:0] OP_MOV = 4'h6;
  localparam logic [3:0] OP_LDI = 4'h7;

  state_t                state;
  logic [3:0]            op_q;
  logic [1:0]            rd_q;
  logic [DATA_WIDTH-1:0] imm_q;
  logic [DATA_WIDTH-1:0] op_a;
  logic [DATA_WIDTH-1:0] op_b;
  logic [DATA_WIDTH-1:0] result;

  logic [DATA_WIDTH:0]   sum;
  logic [DATA_WIDTH:0]   diff;
  logic [DATA_WIDTH-1:0] alu_res;
  logic                  alu_carry;
  logic                  flag_upd;
  logic                  wr_ok;
  logic                  bad_op;

  assign instr_ready   = (state == IDLE);
  assign busy          = (state != IDLE);
  assign rf_input_data = (state == WB) ? result : '0;

  assign sum  = {1'b0, op_a} + {1'b0, op_b};
  assign diff = {1'b0, op_a} - {1'b0, op_b};

  // ALU and opcode decode on the latched instruction and operands
  always_comb begin
    alu_res   = '0;
    alu_carry = 1'b0;
    flag_upd  = 1'b0;
    wr_ok     = 1'b1;
    bad_op    = 1'b0;
    unique case (1'b1)
      (op_q == OP_NOP): wr_ok = 1'b0;
      (op_q == OP_ADD): begin
        alu_res   = sum[DATA_WIDTH-1:0];
        alu_carry = sum[DATA_WIDTH];
        flag_upd  = 1'b1;
      end
      (op_q == OP_SUB): begin
        alu_res   = diff[DATA_WIDTH-1:0];
        alu_carry = diff[DATA_WIDTH];
        flag_upd  = 1'b1;
      end
      (op_q == OP_AND): begin
        alu_res  = op_a & op_b;
        flag_upd = 1'b1;
      end
      (op_q == OP_OR): begin
        alu_res  = op_a | op_b;
        flag_upd = 1'b1;
      end
      (op_q == OP_XOR): begin
        alu_res  = op_a ^ op_b;
        flag_upd = 1'b1;
      end
      (op_q == OP_MOV): alu_res = op_b;
      (op_q == OP_LDI): alu_res = imm_q;
      default: begin
        wr_ok  = 1'b0;
        bad_op = 1'b1;
      end
    endcase
  end

  // Sequencer FSM with registered register-file control
  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= IDLE;
      op_q          <= '0;
      rd_q          <= '0;
      imm_q         <= '0;
      op_a          <= '0;
      op_b          <= '0;
      result        <= '0;
      rf_write_en   <= 1'b0;
      rf_write_sel  <= '0;
      rf_port_a_sel <= '0;
      rf_port_b_sel <= '0;
      done          <= 1'b0;
      flag_zero     <= 1'b0;
      flag_carry    <= 1'b0;
      illegal       <= 1'b0;
      retired_count <= '0;
    end else begin
      done          <= 1'b0;
      rf_write_en   <= 1'b0;
      rf_write_sel  <= '0;
      rf_port_a_sel <= '0;
      rf_port_b_sel <= '0;
      unique case (state)
        IDLE: begin
          if (instr_valid) begin
            op_q          <= instr[7:4];
            rd_q          <= instr[3:2];
            imm_q         <= imm;
            rf_port_a_sel <= instr[3:2];
            rf_port_b_sel <= instr[1:0];
            state         <= READ;
          end
        end
        READ: begin
          op_a  <= rf_port_a_data;
          op_b  <= rf_port_b_data;
          state <= EXEC;
        end
        EXEC: begin
          result <= alu_res;
          if (flag_upd) begin
            flag_zero  <= (alu_res == '0);
            flag_carry <= alu_carry;
          end
          if (bad_op) illegal <= 1'b1;
          rf_write_en   <= wr_ok;
          rf_write_sel  <= rd_q;
          done          <= 1'b1;
          retired_count <= retired_count + COUNT_WIDTH'(1);
          state         <= WB;
        end
        WB: state <= IDLE;
      endcase
    end
  end

endmodule
